// File: rtl/redun_mont_sched.sv
`default_nettype none
// ============================================================================
//  Module   : redun_mont_sched
//  Purpose  : Job sequencer for the redun_mont squaring datapath. Takes a
//             start value and an iteration count T, launches the squarer
//             once, counts its per-iteration valid pulses and captures the
//             T-th result. It then flushes the squarer through a local reset
//             and presents the result on a valid/ready port.
//  Ports    : i_clk/i_rst           clock, synchronous active-high reset
//             i_start_*/o_start_rdy job request (ready only in IDLE)
//             i_abort               cancel job in LAUNCH/RUN
//             o_res_*/i_res_rdy     result handshake
//             o_sq/o_sq_val         launch value/pulse to the squarer
//             o_mont_rst            squarer local reset (flush)
//             i_mul/i_mul_val       per-iteration squarer output
//             o_iter_cnt/o_busy     status
//             o_wdog_err            sticky squarer-stall error
//             o_chk_*               checkpoint port (optional)
//  Options  : `define REDUN_MONT_SCHED_CHKPT_EN adds the checkpoint port.
//  Notes    : WRD_BITS/NUM_WRDS mirror redun_mont_pkg so the block stands
//             alone; operands are NUM_WRDS words of WRD_BITS+1 bits.
//  Revision : 1.0  initial release
// ============================================================================
module redun_mont_sched #(
    parameter int WRD_BITS       = 16,
    parameter int NUM_WRDS       = 4,
    parameter int ITER_BITS      = 64,
    parameter int FLUSH_CYCLES   = 4,
    parameter int WDOG_CYCLES    = 4096,
    parameter int CHKPT_INTERVAL = 1024
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_WRDS-1:0][WRD_BITS:0]    i_start_dat,
    input  logic [ITER_BITS-1:0]               i_start_iter,
    input  logic                               i_start_val,
    output logic                               o_start_rdy,
    input  logic                               i_abort,
    output logic [NUM_WRDS-1:0][WRD_BITS:0]    o_res_dat,
    output logic                               o_res_val,
    input  logic                               i_res_rdy,
    output logic [NUM_WRDS-1:0][WRD_BITS:0]    o_sq,
    output logic                               o_sq_val,
    output logic                               o_mont_rst,
    input  logic [NUM_WRDS-1:0][WRD_BITS:0]    i_mul,
    input  logic                               i_mul_val,
    output logic [ITER_BITS-1:0]               o_iter_cnt,
    output logic                               o_busy,
`ifdef REDUN_MONT_SCHED_CHKPT_EN
    output logic [NUM_WRDS-1:0][WRD_BITS:0]    o_chk_dat,
    output logic [ITER_BITS-1:0]               o_chk_iter,
    output logic                               o_chk_val,
`endif
    output logic                               o_wdog_err
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [FL_W-1:0]      c_FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0]      c_WDOG_LAST  = WD_W'(WDOG_CYCLES - 1);
    localparam logic [ITER_BITS-1:0] c_ITER_ONE   = ITER_BITS'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t                           r_state;
    logic                             r_pending;   // FLUSH exits to HOLD when set
    logic [FL_W-1:0]                  r_flush_cnt;
    logic [WD_W-1:0]                  r_wdog_cnt;
    logic [ITER_BITS-1:0]             r_iter_tgt;
    logic [ITER_BITS-1:0]             r_iter_cnt;
    logic                             r_start_rdy;
    logic                             r_busy;
    logic                             r_res_val;
    logic                             r_sq_val;
    logic                             r_mont_rst;
    logic                             r_wdog_err;
    logic [NUM_WRDS-1:0][WRD_BITS:0]  r_res_dat;
    logic [NUM_WRDS-1:0][WRD_BITS:0]  r_sq;

    logic                             w_accept;
    logic [ITER_BITS-1:0]             w_iter_nxt;

    assign w_accept   = i_start_val & r_start_rdy;
    assign w_iter_nxt = r_iter_cnt + c_ITER_ONE;

`ifdef REDUN_MONT_SCHED_CHKPT_EN
    localparam logic [ITER_BITS-1:0] c_CHK_MASK = ITER_BITS'(CHKPT_INTERVAL - 1);
    logic [NUM_WRDS-1:0][WRD_BITS:0]  r_chk_dat;
    logic [ITER_BITS-1:0]             r_chk_iter;
    logic                             r_chk_val;

    // Only non-final iterations reach here, so w_iter_nxt is already in (0,T).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chk_dat  <= '0;
            r_chk_iter <= '0;
            r_chk_val  <= 1'b0;
        end else begin
            r_chk_val <= 1'b0;
            if (r_state == ST_RUN && !i_abort && i_mul_val &&
                w_iter_nxt != r_iter_tgt && (w_iter_nxt & c_CHK_MASK) == '0) begin
                r_chk_dat  <= i_mul;
                r_chk_iter <= w_iter_nxt;
                r_chk_val  <= 1'b1;
            end
        end
    end

    assign o_chk_dat  = r_chk_dat;
    assign o_chk_iter = r_chk_iter;
    assign o_chk_val  = r_chk_val;
`else
    logic w_unused_chk;
    assign w_unused_chk = (CHKPT_INTERVAL > 0);
`endif

    // Reset parks the FSM in FLUSH (no result pending) so the squarer is
    // held in reset for FLUSH_CYCLES after i_rst drops, then IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_FLUSH;
            r_pending   <= 1'b0;
            r_flush_cnt <= '0;
            r_wdog_cnt  <= '0;
            r_iter_tgt  <= '0;
            r_iter_cnt  <= '0;
            r_start_rdy <= 1'b0;
            r_busy      <= 1'b1;
            r_res_val   <= 1'b0;
            r_sq_val    <= 1'b0;
            r_mont_rst  <= 1'b1;
            r_wdog_err  <= 1'b0;
            r_res_dat   <= '0;
            r_sq        <= '0;
        end else begin
            r_sq_val <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_iter_tgt  <= i_start_iter;
                        r_iter_cnt  <= '0;
                        r_wdog_err  <= 1'b0;
                        r_start_rdy <= 1'b0;
                        r_busy      <= 1'b1;
                        if (i_start_iter == '0) begin
                            // Nothing to square: the start value is the result.
                            r_res_dat <= i_start_dat;
                            r_res_val <= 1'b1;
                            r_state   <= ST_HOLD;
                        end else begin
                            r_sq       <= i_start_dat;
                            r_sq_val   <= 1'b1;
                            r_wdog_cnt <= '0;
                            r_state    <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (i_abort) begin
                        r_state     <= ST_FLUSH;
                        r_pending   <= 1'b0;
                        r_flush_cnt <= '0;
                        r_mont_rst  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        // Abort takes priority over a coincident final pulse.
                        r_state     <= ST_FLUSH;
                        r_pending   <= 1'b0;
                        r_flush_cnt <= '0;
                        r_mont_rst  <= 1'b1;
                    end else if (i_mul_val) begin
                        r_iter_cnt <= w_iter_nxt;
                        r_wdog_cnt <= '0;
                        if (w_iter_nxt == r_iter_tgt) begin
                            r_res_dat   <= i_mul;
                            r_state     <= ST_FLUSH;
                            r_pending   <= 1'b1;
                            r_flush_cnt <= '0;
                            r_mont_rst  <= 1'b1;
                        end
                    end else if (r_wdog_cnt == c_WDOG_LAST) begin
                        // WDOG_CYCLES-th consecutive idle cycle: give up on the job.
                        r_wdog_err  <= 1'b1;
                        r_state     <= ST_FLUSH;
                        r_pending   <= 1'b0;
                        r_flush_cnt <= '0;
                        r_mont_rst  <= 1'b1;
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_mont_rst <= 1'b0;
                        if (r_pending) begin
                            r_res_val <= 1'b1;
                            r_state   <= ST_HOLD;
                        end else begin
                            r_start_rdy <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_res_rdy) begin
                        r_res_val   <= 1'b0;
                        r_pending   <= 1'b0;
                        r_start_rdy <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_FLUSH;
                    r_pending   <= 1'b0;
                    r_flush_cnt <= '0;
                    r_mont_rst  <= 1'b1;
                end
            endcase
        end
    end

    assign o_start_rdy = r_start_rdy;
    assign o_res_dat   = r_res_dat;
    assign o_res_val   = r_res_val;
    assign o_sq        = r_sq;
    assign o_sq_val    = r_sq_val;
    assign o_mont_rst  = r_mont_rst;
    assign o_iter_cnt  = r_iter_cnt;
    assign o_busy      = r_busy;
    assign o_wdog_err  = r_wdog_err;

endmodule
`default_nettype wire
